multicycle_control: RTL
=======================

# multicycle_control

Sequential control unit for the multi-cycle RV32I core; replaces the single-cycle opcode decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back, drives datapath mux selects and enables per step, and stalls on a shared instruction/data memory ready handshake. It also provides a bounded-wait timeout, sticky illegal-opcode trapping and an optional multi-cycle M-extension execute path.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum wait cycles in any memory or muldiv wait state; 0 disables the timeout.
- `TMR_W`, `$clog2(TIMEOUT_CYCLES+1)`: width of the wait counter; derived, not overridden.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Opcode` in 7: instruction opcode field from the IR; stable from DECODE onward.
- `funct7_0` in 1: instruction bit 25; selects MULDIV for R-type when enabled.
- `mem_ready` in 1: memory completed the current request this cycle.
- `muldiv_done` in 1: multiply/divide unit result is valid (used only with macro).
- `pc_write`, `ir_write`, `mem_req`, `mem_we` out 1 each: PC enable, IR enable, memory request, memory write.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result register.
- `alu_src_a` out 2: 00 = rs1, 01 = PC, 10 = old PC.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `ALUOp` out 2, `RWSel` out 2: codes as in the single-cycle core (RWSel 00 = ALU/mem, 01 = PC+4, 10 = imm, 11 = PC+imm).
- `Register_Write`, `Memory2Register`, `Branch`, `JalrSel` out 1 each.
- `muldiv_start` out 1: one-cycle start pulse.
- `illegal`, `timeout` out 1 each: sticky error flags.
- `state` out 4: current state encoding, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, UPPER, MULDIV, TRAP.
- Outputs are combinational from `state` and `Opcode`. Every output not listed for a state is 0.
- IDLE: all outputs 0; next state is FETCH unconditionally.
- FETCH:
  - Drives `mem_req`, `mem_addr_sel`=0, src_a=01, src_b=10, ALUOp=00.
  - While `mem_ready`=0, stays in FETCH.
  - When `mem_ready`=1, asserts `ir_write` and `pc_write` in that same cycle, then goes to DECODE.
- DECODE: src_a=10, src_b=01, ALUOp=00 (branch/JAL target). Next state by opcode:
  - R-type → EXEC_R, or MULDIV when `funct7_0`=1 and the macro is defined.
  - OP-IMM → EXEC_I.
  - LW/SW → MEM_ADDR.
  - BR → BRANCH.
  - JAL/JALR → JUMP.
  - LUI/AUIPC → UPPER.
  - Any other opcode → TRAP.
- EXEC_R: src_a=00, src_b=00, ALUOp=10 → WB_ALU.
- EXEC_I: src_a=00, src_b=01, ALUOp=10 → WB_ALU.
- MEM_ADDR: src_a=00, src_b=01, ALUOp=00 → MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_req`, `mem_addr_sel`=1, `Memory_Read` semantics; waits for `mem_ready`, then → WB_MEM.
- MEM_WR: adds `mem_we`; waits for `mem_ready`, then → FETCH.
- WB_ALU: `Register_Write`, RWSel=00 → FETCH.
- WB_MEM: `Register_Write`, `Memory2Register` → FETCH.
- BRANCH: src_a=00, src_b=00, ALUOp=01, `Branch`; the datapath qualifies the PC load with the compare result. → FETCH.
- JUMP: `Register_Write`, RWSel=01, `pc_write`. Then → FETCH.
  - JALR: `JalrSel`, src_a=00, src_b=01, ALUOp=00.
  - JAL: ALUOp=11, PC loaded from the target computed in DECODE.
- UPPER: `Register_Write`; RWSel=10 for LUI, 11 for AUIPC; ALUOp=11 for LUI, 00 for AUIPC. → FETCH.
- TRAP: `illegal`=1, held until reset; no further fetch.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_RD, MEM_WR or MULDIV, and increments each cycle the awaited handshake is low.
  - When the count equals `TIMEOUT_CYCLES`, the next state is TRAP and `timeout` is set.
  - `timeout` is sticky; `illegal` stays 0 on a timeout trap.
  - `mem_ready` arriving in the same cycle the count reaches its limit wins: the normal transition is taken.
- `mem_ready` outside the wait states is ignored.

## Timing
- Reset: `state`=IDLE immediately, asynchronously; all outputs 0, including `illegal` and `timeout`. A reset mid-instruction abandons the instruction with no write enables.
- First FETCH request occurs on the second rising edge after reset deasserts.
- Cycle counts with zero-wait memory:
  - BR, JAL, JALR, LUI, AUIPC: 3 cycles.
  - R-type, OP-IMM, SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle `mem_ready` is low adds one cycle.
- `muldiv_start` is high only on the first MULDIV cycle.

## Configuration
- `CTRL_MULDIV_EN` defined:
  - MULDIV state exists; `muldiv_start` is pulsed on entry.
  - The FSM waits for `muldiv_done`, then → WB_ALU, with the timeout applied.
- Undefined:
  - No MULDIV state; `muldiv_start` is tied 0 and `muldiv_done` is unused.
  - R-type with `funct7_0`=1 decodes as ordinary EXEC_R.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode constants;
  - the state encoding;
  - ALUOp, RWSel, src_a and src_b codes.
- One sub-module, `ctrl_wait_timer`: clear, enable and `TIMEOUT_CYCLES` compare, producing `expired`.

## Test plan
- Reset, then ADD (0110011) with `mem_ready`=1 → states IDLE, FETCH, DECODE, EXEC_R, WB_ALU, FETCH; `Register_Write`=1 only in WB_ALU.
- LW with `mem_ready` low for 3 cycles in MEM_RD → 8 cycles total; `Memory2Register`=1 only in WB_MEM.
- Opcode 7'b1111111 → TRAP after DECODE; `illegal`=1, and stays 1 until `reset` pulses.
- `mem_ready` held 0 in FETCH with `TIMEOUT_CYCLES`=4 → TRAP after 4 wait cycles, `timeout`=1; with `mem_ready`=1 in the 4th wait cycle → DECODE instead.
- Assert `reset` during MEM_WR → `mem_we` and `mem_req` drop in the same cycle, `state`=IDLE.
- With `CTRL_MULDIV_EN`, R-type with `funct7_0`=1 and `muldiv_done` after 5 cycles → single `muldiv_start` pulse, then WB_ALU.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select codes, the per-state control word and the DECODE dispatch.
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_WB_ALU   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_UPPER    = 4'd12;
    localparam logic [3:0] S_MULDIV   = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;

    localparam logic [1:0] RW_ALU   = 2'b00;
    localparam logic [1:0] RW_PC4   = 2'b01;
    localparam logic [1:0] RW_IMM   = 2'b10;
    localparam logic [1:0] RW_PCIMM = 2'b11;

    localparam logic [1:0] SRCA_RS1   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] rw_sel;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jalr_sel;
    } ctrl_word_t;

    // Unknown opcodes land in TRAP; the caller uses that to set the sticky illegal flag.
    function automatic logic [3:0] decode_next(input logic [6:0] op,
                                               input logic       funct7_0,
                                               input logic       muldiv_en);
        case (op)
            OP_R:              return (muldiv_en && funct7_0) ? S_MULDIV : S_EXEC_R;
            OP_IMM:            return S_EXEC_I;
            OP_LW, OP_SW:      return S_MEM_ADDR;
            OP_BR:             return S_BRANCH;
            OP_JAL, OP_JALR:   return S_JUMP;
            OP_LUI, OP_AUIPC:  return S_UPPER;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle; master is the control FSM side.
interface multicycle_control_if;
  logic [6:0] Opcode;
  logic       funct7_0;
  logic       mem_ready;
  logic       muldiv_done;
  logic       pc_write;
  logic       ir_write;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ALUOp;
  logic [1:0] RWSel;
  logic       Register_Write;
  logic       Memory2Register;
  logic       Branch;
  logic       JalrSel;
  logic       muldiv_start;
  logic       illegal;
  logic       timeout;
  logic [3:0] state;

  modport master (
    input  Opcode, funct7_0, mem_ready, muldiv_done,
    output pc_write, ir_write, mem_req, mem_we, mem_addr_sel,
           alu_src_a, alu_src_b, ALUOp, RWSel,
           Register_Write, Memory2Register, Branch, JalrSel,
           muldiv_start, illegal, timeout, state
  );

  modport slave (
    output Opcode, funct7_0, mem_ready, muldiv_done,
    input  pc_write, ir_write, mem_req, mem_we, mem_addr_sel,
           alu_src_a, alu_src_b, ALUOp, RWSel,
           Register_Write, Memory2Register, Branch, JalrSel,
           muldiv_start, illegal, timeout, state
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Bounded-wait counter: cleared on entry to a wait state, counts cycles the awaited
// handshake is low; expired flags the cycle in which the count reaches TIMEOUT_CYCLES.
module ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TMR_W < 1) ? 1 : TMR_W;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_count;
      assign unused_count = ^count_reg;
      assign expired      = 1'b0;
    end else begin : g_on
      // A low handshake in this cycle is the one that brings the count to the limit.
      assign expired = enable && (int'(count_reg) == TIMEOUT_CYCLES - 1);
    end
  endgenerate
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with memory-ready stalls, bounded-wait timeout and
// sticky traps. Define CTRL_MULDIV_EN to add the multi-cycle M-extension execute state.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CTRL_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic       illegal_reg;
  logic       timeout_reg;
  logic       tmr_en;
  logic       tmr_clr;
  logic       tmr_expired;
  ctrl_word_t cw;

  // Only the handshake being waited on in the current state advances the timer.
  always_comb begin
    tmr_en = 1'b0;
    case (state_reg)
      S_FETCH, S_MEM_RD, S_MEM_WR: tmr_en = !bus.mem_ready;
`ifdef CTRL_MULDIV_EN
      S_MULDIV:                    tmr_en = !bus.muldiv_done;
`endif
      default:                     tmr_en = 1'b0;
    endcase
  end

  assign tmr_clr = (state_next != state_reg);

  ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)    state_next = S_DECODE;
        else if (tmr_expired) state_next = S_TRAP;
      end
      S_DECODE: state_next = decode_next(bus.Opcode, bus.funct7_0, MULDIV_EN);
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_MEM_ADDR: state_next = (bus.Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready)    state_next = S_WB_MEM;
        else if (tmr_expired) state_next = S_TRAP;
      end
      S_MEM_WR: begin
        if (bus.mem_ready)    state_next = S_FETCH;
        else if (tmr_expired) state_next = S_TRAP;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_UPPER: state_next = S_FETCH;
      S_MULDIV: begin
`ifdef CTRL_MULDIV_EN
        if (bus.muldiv_done)  state_next = S_WB_ALU;
        else if (tmr_expired) state_next = S_TRAP;
`else
        state_next = S_TRAP;
`endif
      end
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE && state_next == S_TRAP) begin
        illegal_reg <= 1'b1;
      end
      if (tmr_expired) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    cw = '0;
    case (state_reg)
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.alu_src_a = SRCA_PC;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.ir_write  = bus.mem_ready;
        cw.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        cw.alu_src_a = SRCA_OLDPC;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_RS2;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        cw.mem_req      = 1'b1;
        cw.mem_addr_sel = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_req      = 1'b1;
        cw.mem_addr_sel = 1'b1;
        cw.mem_we       = 1'b1;
      end
      S_WB_ALU: begin
        cw.reg_write = 1'b1;
        cw.rw_sel    = RW_ALU;
      end
      S_WB_MEM: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_RS2;
        cw.alu_op    = ALUOP_BR;
        cw.branch    = 1'b1;
      end
      S_JUMP: begin
        cw.reg_write = 1'b1;
        cw.rw_sel    = RW_PC4;
        cw.pc_write  = 1'b1;
        if (bus.Opcode == OP_JALR) begin
          cw.jalr_sel  = 1'b1;
          cw.alu_src_a = SRCA_RS1;
          cw.alu_src_b = SRCB_IMM;
          cw.alu_op    = ALUOP_ADD;
        end else begin
          // JAL: PC takes the target the ALU produced during DECODE.
          cw.alu_op = ALUOP_PASS;
        end
      end
      S_UPPER: begin
        cw.reg_write = 1'b1;
        if (bus.Opcode == OP_LUI) begin
          cw.rw_sel = RW_IMM;
          cw.alu_op = ALUOP_PASS;
        end else begin
          cw.rw_sel = RW_PCIMM;
          cw.alu_op = ALUOP_ADD;
        end
      end
      default: cw = '0;
    endcase
  end

`ifdef CTRL_MULDIV_EN
  logic prev_not_muldiv_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_not_muldiv_reg <= 1'b1;
    end else begin
      prev_not_muldiv_reg <= (state_reg != S_MULDIV);
    end
  end

  assign bus.muldiv_start = (state_reg == S_MULDIV) && prev_not_muldiv_reg;
`else
  logic unused_muldiv_done;
  assign unused_muldiv_done = bus.muldiv_done;
  assign bus.muldiv_start   = 1'b0;
`endif

  assign bus.pc_write        = cw.pc_write;
  assign bus.ir_write        = cw.ir_write;
  assign bus.mem_req         = cw.mem_req;
  assign bus.mem_we          = cw.mem_we;
  assign bus.mem_addr_sel    = cw.mem_addr_sel;
  assign bus.alu_src_a       = cw.alu_src_a;
  assign bus.alu_src_b       = cw.alu_src_b;
  assign bus.ALUOp           = cw.alu_op;
  assign bus.RWSel           = cw.rw_sel;
  assign bus.Register_Write  = cw.reg_write;
  assign bus.Memory2Register = cw.mem_to_reg;
  assign bus.Branch          = cw.branch;
  assign bus.JalrSel         = cw.jalr_sel;
  assign bus.illegal         = illegal_reg;
  assign bus.timeout         = timeout_reg;
  assign bus.state           = state_reg;
endmodule
